// File: rtl/byte_shift_counter.sv
// byte_shift_counter: 64-bit (BYTES deep) byte-wide shift register plus a
// bounded wrapping up-counter used by the NTR command receiver datapath.
// The shifter assembles the command word MSB-first; the counter tracks how
// many bytes have been sampled and wraps from CNT_MAX back to 0.
module byte_shift_counter #(
  parameter int BYTES     = 8,
  parameter int CNT_WIDTH = 4,
  parameter int CNT_MAX   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data_in,
  input  logic                   shift_en,
  input  logic                   shift_clr,
  output logic [8*BYTES-1:0]     data_out,
  input  logic                   cnt_en,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   count,
  output logic                   cnt_at_max
);

  localparam int                   DW      = 8 * BYTES;
  localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(CNT_MAX);

  logic [DW-1:0]        shift_q;
  logic [DW-1:0]        shift_d;
  logic [DW-1:0]        shifted;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 at_max;

  // A single-byte register has no older bytes to keep, so the shifted
  // value is just the incoming byte; otherwise drop the MSB byte.
  generate
    if (BYTES == 1) begin : g_one_byte
      assign shifted = data_in;
    end else begin : g_multi_byte
      assign shifted = {shift_q[DW-9:0], data_in};
    end
  endgenerate

  // Terminal-count flag looks only at the registered count.
  assign at_max = (count_q == CNT_TOP);

  // Next shift-register value: clear beats shift, otherwise hold.
  always_comb begin
    shift_d = shift_q;
    if (shift_clr) begin
      shift_d = '0;
    end else if (shift_en) begin
      shift_d = shifted;
    end
  end

  // Next count: clear beats enable; enable at terminal count wraps to 0.
  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (cnt_en) begin
      if (at_max) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset dominating clear and enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  assign data_out   = shift_q;
  assign count      = count_q;
  assign cnt_at_max = at_max;

endmodule

// File: tb/tb_byte_shift_counter.sv
// Self-checking bench for byte_shift_counter: directed scenarios followed by
// randomized traffic, compared against a behavioural model each cycle.
module tb_byte_shift_counter;

  localparam int BYTES     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = 8;

  logic                 clk;
  logic                 rst;
  logic [7:0]           data_in;
  logic                 shift_en;
  logic                 shift_clr;
  logic [8*BYTES-1:0]   data_out;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic [CNT_WIDTH-1:0] count;
  logic                 cnt_at_max;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [63:0] m_data;
  int          m_cnt;

  byte_shift_counter #(
    .BYTES(BYTES), .CNT_WIDTH(CNT_WIDTH), .CNT_MAX(CNT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en),
    .shift_clr(shift_clr), .data_out(data_out), .cnt_en(cnt_en),
    .cnt_clr(cnt_clr), .count(count), .cnt_at_max(cnt_at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, data_out, m_data);
    check({tag, ".count"}, 64'(count), 64'(m_cnt));
    check({tag, ".at_max"}, 64'(cnt_at_max), 64'(m_cnt == CNT_MAX));
  endtask

  // Advance one clock edge, update the model from the applied inputs, check.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      m_data = '0;
      m_cnt  = 0;
    end else begin
      if (shift_clr)     m_data = '0;
      else if (shift_en) m_data = (m_data << 8) | 64'(data_in);
      if (cnt_clr)       m_cnt = 0;
      else if (cnt_en)   m_cnt = (m_cnt + 1) % (CNT_MAX + 1);
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    shift_en = 0; shift_clr = 0; cnt_en = 0; cnt_clr = 0;
  endtask

  initial begin
    logic [7:0]  asm_bytes [9];
    logic [7:0]  hs_bytes  [9];
    logic [63:0] snap_data;
    logic [63:0] exp_word;
    int          snap_cnt;

    asm_bytes = '{8'h9F, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    m_data = '0; m_cnt = 0;
    rst = 1; data_in = 8'h00; idle_inputs();

    // Reset state, including enables sampled while rst is high
    #1;
    check_all("reset_async");
    shift_en = 1; cnt_en = 1; data_in = 8'h5A;
    step("reset_held_en");
    rst = 0;
    // First edge after reset release behaves as from reset
    step("post_reset_first");
    check("post_reset_count1", 64'(count), 64'd1);

    // Byte assembly: 9 bytes, first discarded
    idle_inputs(); shift_clr = 1; cnt_clr = 1;
    step("asm_clear");
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      data_in = asm_bytes[i]; shift_en = 1; cnt_en = 1;
      step($sformatf("asm_byte%0d", i));
    end
    check("asm_word", data_out, 64'h0011223344556677);

    // Hold: enables low while data_in toggles
    snap_data = data_out; snap_cnt = int'(count);
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      data_in = 8'($urandom);
      step($sformatf("hold%0d", i));
    end
    check("hold_data", data_out, snap_data);
    check("hold_count", 64'(count), 64'(snap_cnt));

    // Wrap: 20 cycles of cnt_en from 0
    cnt_clr = 1;
    step("wrap_clear");
    cnt_clr = 0; cnt_en = 1;
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("wrap%0d", i));
      check($sformatf("wrap_seq%0d", i), 64'(count), 64'(i % 9));
      check($sformatf("wrap_max%0d", i), 64'(cnt_at_max), 64'((i % 9) == 8));
    end

    // Async reset mid-cycle after loading nonzero state
    shift_en = 1; data_in = 8'hC3;
    step("pre_rst_load");
    #2 rst = 1;
    #1;
    check("mid_rst_data", data_out, 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    m_data = '0; m_cnt = 0;
    rst = 0;

    // Clear priority at count = 5
    idle_inputs(); shift_en = 1; cnt_en = 1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(i + 1);
      step($sformatf("prio_load%0d", i));
    end
    check("prio_at5", 64'(count), 64'd5);
    cnt_clr = 1; cnt_en = 1; shift_clr = 1; shift_en = 1; data_in = 8'hAA;
    step("prio_clear");
    check("prio_count0", 64'(count), 64'd0);
    check("prio_data0", data_out, 64'd0);

    // Parent handshake: tied enables, 9 pulses with 1-3 idle gaps
    idle_inputs(); shift_clr = 1; cnt_clr = 1;
    step("hs_clear");
    idle_inputs();
    for (int i = 0; i < 9; i++) begin
      hs_bytes[i] = 8'($urandom);
      if (i == 8) begin
        check("hs_pre_count8", 64'(count), 64'd8);
        check("hs_pre_atmax", 64'(cnt_at_max), 64'd1);
      end
      data_in = hs_bytes[i]; shift_en = 1; cnt_en = 1;
      step($sformatf("hs_pulse%0d", i));
      idle_inputs();
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        data_in = 8'($urandom);
        step("hs_gap");
      end
    end
    exp_word = '0;
    for (int i = 1; i < 9; i++) exp_word = (exp_word << 8) | 64'(hs_bytes[i]);
    check("hs_count0", 64'(count), 64'd0);
    check("hs_word", data_out, exp_word);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      data_in   = 8'($urandom);
      shift_en  = 1'($urandom_range(0, 1));
      cnt_en    = 1'($urandom_range(0, 3) != 0);
      shift_clr = ($urandom_range(0, 15) == 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      step("rand");
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1;
        #1;
        m_data = '0; m_cnt = 0;
        check_all("rand_rst");
        rst = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/byte_shift_counter.md
# byte_shift_counter

Datapath core for the NTR parallel command receiver. It combines a 64-bit byte-wide shift register with a bounded, wrapping up-counter. The receiver FSM pulses one enable per sampled bus byte: the shifter assembles the command word and the counter tracks how many bytes have been sampled. Control (edge detection, chip-select handling, ready flag) is outside this block.

## Interface
Parameters:
- `BYTES`, 8: shift-register depth in bytes; `data_out` width = 8*BYTES.
- `CNT_WIDTH`, 4: counter width in bits.
- `CNT_MAX`, 8: terminal count; must satisfy 0 < CNT_MAX < 2^CNT_WIDTH.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset of all state.
- `data_in` in 8: byte to shift in.
- `shift_en` in 1: shift `data_in` into the register this cycle.
- `shift_clr` in 1: synchronous clear of the shift register.
- `data_out` out 8*BYTES: shift-register contents, registered.
- `cnt_en` in 1: increment counter this cycle.
- `cnt_clr` in 1: synchronous clear of the counter.
- `count` out CNT_WIDTH: counter value, registered.
- `cnt_at_max` out 1: combinational, 1 when `count == CNT_MAX`.

## Operation
- Shift register, per rising edge (priority order):
  - `shift_clr` = 1: `data_out` becomes 0.
  - Else `shift_en` = 1: `data_out` becomes `{data_out[8*BYTES-9:0], data_in}`. The new byte enters the LSB byte and the oldest (MSB) byte is discarded.
  - Otherwise `data_out` holds.
- After the last shift, the first-received byte of the final BYTES bytes is in `data_out[8*BYTES-1 -: 8]`. This is big-endian command order.
- Counter, per rising edge (priority order):
  - `cnt_clr` = 1: `count` becomes 0.
  - Else `cnt_en` = 1 and `count == CNT_MAX`: `count` wraps to 0.
  - Else `cnt_en` = 1: `count` becomes `count + 1`.
  - Otherwise `count` holds.
- The counter never exceeds CNT_MAX and does not free-run to 2^CNT_WIDTH-1.
- The shifter and counter are independent. The parent ties `shift_en` and `cnt_en` together, so a terminal-count check on the pre-increment `count` coincides with the CNT_MAX+1-th byte being shifted in.
- `rst` = 1: `data_out` = 0 and `count` = 0 immediately, regardless of clock. Reset dominates clear and enable.
- `cnt_at_max` derives from `count` only. Its reset value is 0.

## Timing
- One-cycle latency: inputs sampled at edge N are visible on `data_out`/`count` after edge N.
- Edge cases:
  - `shift_clr` and `shift_en` together: clear wins, nothing is shifted.
  - `cnt_clr` and `cnt_en` together: clear wins, `count` = 0.
  - `cnt_en` held continuously: `count` sequence is 0,1,…,CNT_MAX,0,1,…, a period of CNT_MAX+1 cycles.
  - `rst` asserted mid-operation: outputs go to 0 asynchronously. After `rst` deasserts, the first edge behaves as from reset (e.g. with `cnt_en`=1, `count` = 1).
  - Enables sampled while `rst` = 1 have no effect.
- Reset values: `data_out` = 0, `count` = 0, `cnt_at_max` = 0.

## Test plan
- Reset: pulse `rst` between clock edges after loading nonzero state -> `data_out` = 0 and `count` = 0 before the next edge.
- Byte assembly (BYTES=8): shift in 0x9F,0x00,0x11,0x22,0x33,0x44,0x55,0x66,0x77 with `shift_en` one cycle each -> `data_out` = 64'h0011223344556677, with the first byte discarded.
- Hold: deassert `shift_en`/`cnt_en` for 5 cycles while toggling `data_in` -> `data_out` and `count` unchanged.
- Wrap: `cnt_en` held for 20 cycles (CNT_MAX=8) -> `count` goes 1..8,0,1..8,0,1,2. `cnt_at_max` = 1 exactly on the cycles where `count` = 8.
- Clear priority: at `count` = 5 assert `cnt_clr`+`cnt_en`, and `shift_clr`+`shift_en` with `data_in`=0xAA -> next cycle `count` = 0, `data_out` = 0.
- Parent handshake emulation: tie the enables, clear both, then pulse 9 bytes with idle gaps of 1–3 cycles -> pre-increment `count` = 8 on the 9th pulse, then `count` = 0 afterwards, and `data_out` holds the last 8 bytes.
